sync_fifo: RTL
==============

// Module: sync_fifo
// PURPOSE
//   Single-clock synchronous FIFO that produces the push/pop/full/empty handshake watched by the
//   FIFO protocol checker on my_if. Buffers DEPTH words between a producer and a consumer,
//   exposes occupancy and threshold flags, and records protocol violations in sticky error bits.
// PARAMETERS
//   WIDTH      8   data word width in bits
//   DEPTH      16  number of entries; power of two, >= 4
//   AF_LEVEL   12  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL   4   almost_empty asserts when count <= AE_LEVEL
// PORTS
//   clk           in   1            single clock; all logic on posedge
//   rstn          in   1            reset, asynchronous assert, active-low
//   push          in   1            write request; din captured if accepted
//   din           in   WIDTH        write data
//   pop           in   1            read request
//   dout          out  WIDTH        read data, registered
//   rd_valid      out  1            dout holds data from the pop accepted last cycle
//   full          out  1            count == DEPTH
//   empty         out  1            count == 0
//   almost_full   out  1            count >= AF_LEVEL
//   almost_empty  out  1            count <= AE_LEVEL
//   count         out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   overflow      out  1            sticky: push seen while full
//   underflow     out  1            sticky: pop seen while empty
//   clr_err       in   1            synchronous clear of overflow/underflow
// BEHAVIOUR
//   - Reset (rstn low, async): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0,
//     almost_full=0, dout=0, rd_valid=0, overflow=0, underflow=0. Memory contents not reset.
//   - Accept rules, evaluated on flag values at the current edge (before update):
//       push_ok = push & !full;  pop_ok = pop & !empty.
//   - push_ok: mem[wr_ptr]<=din, wr_ptr wraps DEPTH-1 -> 0.
//   - pop_ok: dout<=mem[rd_ptr] next cycle, rd_valid=1 for that one cycle; rd_ptr wraps.
//     No pop_ok: dout holds last value, rd_valid=0. Read latency: 1 cycle.
//   - count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
//   - Flags are registered and derived from next count, so they are valid the cycle after update.
//   - Simultaneous push+pop: full -> pop accepted, push dropped, overflow set;
//     empty -> push accepted, pop dropped, underflow set; otherwise both accepted, count unchanged.
//   - push & full -> write dropped, pointers unchanged, overflow<=1 (sticky).
//   - pop & empty -> no read, rd_valid=0, underflow<=1 (sticky).
//   - clr_err clears both sticky bits; a violation in the same cycle wins (bit stays 1).
//   - Reset mid-operation discards all stored data; first write after release lands at entry 0.
//   - Pointers are $clog2(DEPTH) bits; full/empty come from count, not pointer compare.
// STRUCTURE
//   - fifo_pkg: WIDTH/DEPTH defaults, ptr_t/cnt_t typedefs sized from DEPTH, helper
//     function next_ptr() for wrap.
//   - Sub-module fifo_mem: DEPTH x WIDTH array, one write port, one registered read port.
//   - Top holds pointers, counter, flag registers, error bits.
// TESTING
//   1 Reset: hold rstn=0 3 cycles -> empty=1, almost_empty=1, count=0, full=0, errors=0.
//   2 Fill/drain: push 16 words 0x00..0x0F, then pop 16 -> full=1 after 16th push,
//     almost_full at count 12, dout order 0x00..0x0F each 1 cycle after its pop, empty=1 at end.
//   3 Overflow: at full, push 0xAA -> count stays 16, overflow=1, 0xAA never read out;
//     clr_err -> overflow=0.
//   4 Underflow: empty, pop -> rd_valid=0, underflow=1, count=0; push+pop same cycle while
//     empty -> count=1, underflow=1.
//   5 Wrap/simultaneous: fill 10, then 40 cycles push+pop with incrementing data -> count
//     stays 10, data strictly in order across pointer wrap, no error bits.
//   6 Reset mid-operation: count=7, pulse rstn low asynchronously -> flags reset immediately;
//     push 0x55, pop -> dout=0x55.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared defaults, pointer/count typedefs and helpers for the sync_fifo slice.
//   ptr_t / cnt_t are sized for the default depth; modules built with another
//   DEPTH size their own registers from their parameter.
package fifo_pkg;

  localparam int FIFO_WIDTH    = 8;
  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_AF_LEVEL = 12;
  localparam int FIFO_AE_LEVEL = 4;

  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef logic [FIFO_PTR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0] cnt_t;

  // Advance a ring pointer, wrapping depth-1 back to 0. Works on a 32-bit
  // carrier so any module can reuse it and cast the result to its own width.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int depth);
    if (ptr == 32'(depth) - 32'd1) begin
      return '0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x WIDTH storage with one write port and one registered read port.
//   Ports:
//     clk      in   clock
//     rstn     in   async active-low reset (read register only, array is not reset)
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read strobe; rd_data updates on the next edge
//     rd_addr  in   read address
//     rd_data  out  registered read data, holds its value when rd_en is low
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy flags and sticky protocol
//   error bits.
//   Ports:
//     clk, rstn               clock, async active-low reset
//     push, din               write request and data
//     pop                     read request
//     dout, rd_valid          read data (1-cycle latency) and its valid strobe
//     full, empty             count == DEPTH / count == 0
//     almost_full/_empty      count >= AF_LEVEL / count <= AE_LEVEL
//     count                   occupancy 0..DEPTH
//     overflow, underflow     sticky: push while full / pop while empty
//     clr_err                 synchronous clear of the sticky bits
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic push_ok;
  logic pop_ok;

  // Acceptance uses the registered flags, so a simultaneous push+pop at full
  // drops the push and at empty drops the pop.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop  & ~empty_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_ok) begin
      wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
    end
    if (pop_ok) begin
      rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags come from the next count so they line up with count itself.
    full_d      = (count_d == DEPTH_C);
    empty_d     = (count_d == '0);
    af_d        = (count_d >= AF_C);
    ae_d        = (count_d <= AE_C);
    rd_valid_d  = pop_ok;

    // A violation in the same cycle as clr_err keeps the bit set.
    overflow_d  = (overflow_q  & ~clr_err) | (push & full_q);
    underflow_d = (underflow_q & ~clr_err) | (pop  & empty_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reads and writes never target the same entry in one cycle: with both
  // accepted the FIFO is neither empty nor full, so the pointers differ.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
